sigma_delta_mixer: RTL and testbench
====================================

SIGMA_DELTA_MIXER -- requirements
Module: sigma_delta_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of input channels (1..8).
REQ-002 SHALL have parameter IN_BITS, default 16, per-channel sample width (8..24).
REQ-003 SHALL have parameter ORDER, default 1, modulator order (1 or 2).
REQ-004 SHALL have parameter SIGNED_IN, default 0, 0 = offset-binary inputs (midscale = 2^(IN_BITS-1)), 1 = two's complement.
REQ-005 SHALL have port clk_i  in  1  sole clock; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port res_n_i  in  1  asynchronous active-low reset.
REQ-007 SHALL have port sample_stb_i  in  1  one-cycle request to capture a new sample set.
REQ-008 SHALL have port ch_data_i  in  NUM_CH*IN_BITS  channel samples, channel n at [n*IN_BITS +: IN_BITS].
REQ-009 SHALL have port ch_vol_i  in  NUM_CH*4  per-channel gain code.
REQ-010 SHALL have port ch_route_i  in  NUM_CH*2  bit0 = to left, bit1 = to right.
REQ-011 SHALL have port mute_i  in  1  forces both modulator inputs to signed zero.
REQ-012 SHALL have port dac_l_o  out  1  left 1-bit delta-sigma output.
REQ-013 SHALL have port dac_r_o  out  1  right 1-bit delta-sigma output.
REQ-014 SHALL have port busy_o  out  1  mix sequencer active.
REQ-015 SHALL have port clip_o  out  1  one-cycle pulse, saturation occurred on either side.

Function
REQ-016 Capture: edge E0 where sample_stb_i=1 and state IDLE SHALL latch data, vol, route into holding registers; SIGNED_IN=0 data converted to signed by inverting MSB.
REQ-017 Sequencer SHALL be IDLE -> ACC (exactly NUM_CH cycles, channel 0 first) -> SAT (1 cycle) -> IDLE or ACC if pending.
REQ-018 busy_o SHALL be 1 from E0+1 through the cycle after the SAT edge E(NUM_CH+1); mix_l/mix_r registers SHALL update on E(NUM_CH+1).
REQ-019 Strobe while busy SHALL set a one-deep pending slot (data/vol/route latched); a further strobe while pending SHALL overwrite it; pending set SHALL start ACC directly after SAT with no IDLE cycle.
REQ-020 Strobe coinciding with SAT edge SHALL be treated as pending.
REQ-021 Gain: term = sample * vol (signed*unsigned 4-bit); vol 8 = unity, vol 0 = silent; accumulators SHALL be IN_BITS+5+clog2(NUM_CH) bits, no wrap possible.
REQ-022 Route bits SHALL gate accumulation per side; route 00 contributes nothing.
REQ-023 SAT: result = acc arithmetic-shift-right 3, saturated to signed IN_BITS range; clip_o=1 for exactly the cycle after E(NUM_CH+1) if either side saturated.
REQ-024 Modulators SHALL run every clock on mix_l/mix_r (or 0 when mute_i=1, effective next cycle).
REQ-025 ORDER 1: IN_BITS+1-bit accumulator adds offset-binary input each cycle; output = carry; midscale input -> 50% duty.
REQ-026 ORDER 2: i1 += x - fb; i2 += i1 - fb; y = (i2 >= 0); fb = y ? +2^(IN_BITS-1) : -2^(IN_BITS-1); integrators IN_BITS+4 bits, saturating, never wrapping.

Reset
REQ-027 res_n_i low SHALL immediately force state IDLE, pending clear, holding/mix/integrator registers 0, dac_l_o=dac_r_o=busy_o=clip_o=0, aborting any in-flight mix.
REQ-028 First strobe after release SHALL behave as from power-up.

Structure
REQ-029 Package sigma_delta_pkg SHALL hold state enum (IDLE, ACC, SAT), VOL_SHIFT=3, VOL_UNITY=8, accumulator-width function.
REQ-030 One sub-module sd_modulator (parameters IN_BITS, ORDER) SHALL be instantiated per side.

Verification
REQ-031 NUM_CH=2, ORDER=1, unsigned: ch0=0xFFFF vol 8 route L, ch1=0x8000; strobe -> mix_l=0x7FFF at E3, busy high 3 cycles, dac_l duty 65535/65536 ±1 over 65536 cycles.
REQ-032 Both channels 0xFFFF vol 15 route 11 -> mix_l=mix_r=0x7FFF, clip_o high exactly one cycle.
REQ-033 Strobes at E0, E1 (A then B), E2 (C) -> two mixes, second reflects C, no IDLE cycle between, B never mixed.
REQ-034 Reset asserted mid-ACC -> all outputs 0 immediately, no clip_o, next strobe mixes normally.
REQ-035 ORDER=2, midscale input -> dac duty 50% ±1 over 1024 cycles; full-scale negative input for 10^5 cycles -> integrators saturate, never wrap, dac 0 ≥99.9%.
REQ-036 mute_i=1 with full-scale mix -> both outputs 50% duty; vol 0 or route 00 channel -> no contribution.

Source files
------------

// File: rtl/sigma_delta_pkg.sv
// Shared types and constants for the sigma-delta mixer.
// Holds the sequencer state encoding, gain scaling and the accumulator sizing rule.
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT
    } state_t;

    localparam int VOL_SHIFT = 3;
    localparam int VOL_UNITY = 8;

    // Wide enough that NUM_CH full-scale samples at maximum gain can never wrap.
    function automatic int accWidth(input int inBits, input int numCh);
        return inBits + 5 + $clog2(numCh);
    endfunction

endpackage

// File: rtl/sd_modulator.sv
// One-bit delta-sigma modulator for a signed IN_BITS input.
// Order 1 is a phase accumulator; order 2 is a two-integrator loop with saturating integrators.
module sd_modulator #(
    parameter int IN_BITS = 16,
    parameter int ORDER   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic signed [IN_BITS-1:0] i_x,
    output logic                      o_dac
);

    logic r_dac;

    assign o_dac = r_dac;

    generate
        if (ORDER == 1) begin : g_order1
            logic [IN_BITS-1:0] r_phase;
            logic [IN_BITS:0]   w_phaseSum;

            // Offset-binary input: the carry rate equals input / 2^IN_BITS.
            assign w_phaseSum = {1'b0, r_phase} + {1'b0, ~i_x[IN_BITS-1], i_x[IN_BITS-2:0]};

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_phase <= '0;
                    r_dac   <= 1'b0;
                end else begin
                    r_phase <= w_phaseSum[IN_BITS-1:0];
                    r_dac   <= w_phaseSum[IN_BITS];
                end
            end
        end else begin : g_order2
            localparam int IW = IN_BITS + 4;
            localparam int WW = IW + 2;
            localparam logic signed [IW-1:0] FB_MAG  = {{(IW-IN_BITS){1'b0}}, 1'b1, {(IN_BITS-1){1'b0}}};
            localparam logic signed [IW-1:0] INT_MAX = {1'b0, {(IW-1){1'b1}}};
            localparam logic signed [IW-1:0] INT_MIN = {1'b1, {(IW-1){1'b0}}};

            logic signed [IW-1:0] r_int1;
            logic signed [IW-1:0] r_int2;
            logic signed [IW-1:0] w_fb;
            logic signed [IW-1:0] w_int1Next;
            logic signed [IW-1:0] w_int2Next;
            logic signed [WW-1:0] w_sum1;
            logic signed [WW-1:0] w_sum2;

            function automatic logic signed [WW-1:0] extInt(input logic signed [IW-1:0] v);
                return $signed({{2{v[IW-1]}}, v});
            endfunction

            function automatic logic signed [IW-1:0] satInt(input logic signed [WW-1:0] v);
                if (v > extInt(INT_MAX)) begin
                    return INT_MAX;
                end else if (v < extInt(INT_MIN)) begin
                    return INT_MIN;
                end
                return v[IW-1:0];
            endfunction

            assign w_fb       = r_dac ? FB_MAG : -FB_MAG;
            assign w_sum1     = extInt(r_int1) + $signed({{(WW-IN_BITS){i_x[IN_BITS-1]}}, i_x}) - extInt(w_fb);
            assign w_int1Next = satInt(w_sum1);
            assign w_sum2     = extInt(r_int2) + extInt(w_int1Next) - extInt(w_fb);
            assign w_int2Next = satInt(w_sum2);

            // The output bit is the sign of the freshly updated second integrator.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_int1 <= '0;
                    r_int2 <= '0;
                    r_dac  <= 1'b0;
                end else begin
                    r_int1 <= w_int1Next;
                    r_int2 <= w_int2Next;
                    r_dac  <= ~w_int2Next[IW-1];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sigma_delta_mixer.sv
// Multi-channel gain/route mixer feeding a left and a right 1-bit delta-sigma modulator.
// A sequencer walks the channels one per clock, then saturates and publishes the mix.
module sigma_delta_mixer #(
    parameter int NUM_CH    = 2,
    parameter int IN_BITS   = 16,
    parameter int ORDER     = 1,
    parameter int SIGNED_IN = 0
) (
    input  logic                        clk_i,
    input  logic                        res_n_i,
    input  logic                        sample_stb_i,
    input  logic [NUM_CH*IN_BITS-1:0]   ch_data_i,
    input  logic [NUM_CH*4-1:0]         ch_vol_i,
    input  logic [NUM_CH*2-1:0]         ch_route_i,
    input  logic                        mute_i,
    output logic                        dac_l_o,
    output logic                        dac_r_o,
    output logic                        busy_o,
    output logic                        clip_o
);

    import sigma_delta_pkg::*;

    localparam int ACC_W = accWidth(IN_BITS, NUM_CH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-IN_BITS+1){1'b0}}, {(IN_BITS-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-IN_BITS+1){1'b1}}, {(IN_BITS-1){1'b0}}};

    state_t                      r_state;
    logic [CH_W-1:0]             r_chIdx;
    logic [NUM_CH*IN_BITS-1:0]   r_holdData;
    logic [NUM_CH*4-1:0]         r_holdVol;
    logic [NUM_CH*2-1:0]         r_holdRoute;
    logic [NUM_CH*IN_BITS-1:0]   r_pendData;
    logic [NUM_CH*4-1:0]         r_pendVol;
    logic [NUM_CH*2-1:0]         r_pendRoute;
    logic                        r_pending;
    logic signed [ACC_W-1:0]     r_accL;
    logic signed [ACC_W-1:0]     r_accR;
    logic signed [IN_BITS-1:0]   r_mixL;
    logic signed [IN_BITS-1:0]   r_mixR;
    logic                        r_busy;
    logic                        r_clip;

    logic [NUM_CH*IN_BITS-1:0]   w_capData;
    logic signed [IN_BITS-1:0]   w_sample;
    logic [3:0]                  w_vol;
    logic [1:0]                  w_route;
    logic signed [ACC_W-1:0]     w_term;
    logic signed [ACC_W-1:0]     w_shL;
    logic signed [ACC_W-1:0]     w_shR;
    logic signed [IN_BITS-1:0]   w_modInL;
    logic signed [IN_BITS-1:0]   w_modInR;

    function automatic logic signed [IN_BITS-1:0] satVal(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[IN_BITS-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[IN_BITS-1:0];
        end
        return v[IN_BITS-1:0];
    endfunction

    function automatic logic isSat(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // Offset-binary lanes become two's complement by flipping each lane's MSB.
    always_comb begin
        w_capData = ch_data_i;
        if (SIGNED_IN == 0) begin
            for (int n = 0; n < NUM_CH; n++) begin
                w_capData[n*IN_BITS + IN_BITS - 1] = ~ch_data_i[n*IN_BITS + IN_BITS - 1];
            end
        end
    end

    assign w_sample = $signed(r_holdData[r_chIdx*IN_BITS +: IN_BITS]);
    assign w_vol    = r_holdVol[r_chIdx*4 +: 4];
    assign w_route  = r_holdRoute[r_chIdx*2 +: 2];
    assign w_term   = $signed({{(ACC_W-IN_BITS){w_sample[IN_BITS-1]}}, w_sample})
                    * $signed({{(ACC_W-4){1'b0}}, w_vol});
    assign w_shL    = r_accL >>> VOL_SHIFT;
    assign w_shR    = r_accR >>> VOL_SHIFT;

    // A strobe landing on the SAT edge is consumed straight away so ACC follows with no IDLE gap.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_state     <= IDLE;
            r_chIdx     <= '0;
            r_holdData  <= '0;
            r_holdVol   <= '0;
            r_holdRoute <= '0;
            r_pendData  <= '0;
            r_pendVol   <= '0;
            r_pendRoute <= '0;
            r_pending   <= 1'b0;
            r_accL      <= '0;
            r_accR      <= '0;
            r_mixL      <= '0;
            r_mixR      <= '0;
            r_busy      <= 1'b0;
            r_clip      <= 1'b0;
        end else begin
            r_clip <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_stb_i) begin
                        r_holdData  <= w_capData;
                        r_holdVol   <= ch_vol_i;
                        r_holdRoute <= ch_route_i;
                        r_accL      <= '0;
                        r_accR      <= '0;
                        r_chIdx     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ACC;
                    end
                end
                ACC: begin
                    if (w_route[0]) r_accL <= r_accL + w_term;
                    if (w_route[1]) r_accR <= r_accR + w_term;
                    if (sample_stb_i) begin
                        r_pendData  <= w_capData;
                        r_pendVol   <= ch_vol_i;
                        r_pendRoute <= ch_route_i;
                        r_pending   <= 1'b1;
                    end
                    if (r_chIdx == LAST_CH) begin
                        r_state <= SAT;
                    end else begin
                        r_chIdx <= r_chIdx + 1'b1;
                    end
                end
                SAT: begin
                    r_mixL  <= satVal(w_shL);
                    r_mixR  <= satVal(w_shR);
                    r_clip  <= isSat(w_shL) || isSat(w_shR);
                    r_accL  <= '0;
                    r_accR  <= '0;
                    r_chIdx <= '0;
                    if (r_pending) begin
                        r_holdData  <= r_pendData;
                        r_holdVol   <= r_pendVol;
                        r_holdRoute <= r_pendRoute;
                        r_pending   <= sample_stb_i;
                        if (sample_stb_i) begin
                            r_pendData  <= w_capData;
                            r_pendVol   <= ch_vol_i;
                            r_pendRoute <= ch_route_i;
                        end
                        r_state <= ACC;
                    end else if (sample_stb_i) begin
                        r_holdData  <= w_capData;
                        r_holdVol   <= ch_vol_i;
                        r_holdRoute <= ch_route_i;
                        r_state     <= ACC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign clip_o   = r_clip;
    assign w_modInL = mute_i ? '0 : r_mixL;
    assign w_modInR = mute_i ? '0 : r_mixR;

    sd_modulator #(
        .IN_BITS (IN_BITS),
        .ORDER   (ORDER)
    ) u_modL (
        .i_clk   (clk_i),
        .i_rst_n (res_n_i),
        .i_x     (w_modInL),
        .o_dac   (dac_l_o)
    );

    sd_modulator #(
        .IN_BITS (IN_BITS),
        .ORDER   (ORDER)
    ) u_modR (
        .i_clk   (clk_i),
        .i_rst_n (res_n_i),
        .i_x     (w_modInR),
        .o_dac   (dac_r_o)
    );

endmodule

// File: tb/tb_sigma_delta_mixer.sv
// Randomized and directed bench for sigma_delta_mixer against an arithmetic mix model.
// A second instance with ORDER=2 covers the second-order modulator behaviour.
module tb_sigma_delta_mixer;

    localparam int NCH = 2;
    localparam int IB  = 16;

    logic        clk = 1'b0;
    logic        resN;
    logic        sampleStb;
    logic [31:0] chData;
    logic [7:0]  chVol;
    logic [3:0]  chRoute;
    logic        mute;
    logic        dacL;
    logic        dacR;
    logic        busy;
    logic        clip;

    logic        stb2;
    logic [31:0] data2;
    logic [7:0]  vol2;
    logic [3:0]  route2;
    logic        mute2;
    logic        dac2L;
    logic        dac2R;
    logic        busy2;
    logic        clip2;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    sigma_delta_mixer #(.NUM_CH(NCH), .IN_BITS(IB), .ORDER(1), .SIGNED_IN(0)) dut (
        .clk_i        (clk),
        .res_n_i      (resN),
        .sample_stb_i (sampleStb),
        .ch_data_i    (chData),
        .ch_vol_i     (chVol),
        .ch_route_i   (chRoute),
        .mute_i       (mute),
        .dac_l_o      (dacL),
        .dac_r_o      (dacR),
        .busy_o       (busy),
        .clip_o       (clip)
    );

    sigma_delta_mixer #(.NUM_CH(NCH), .IN_BITS(IB), .ORDER(2), .SIGNED_IN(0)) dut2 (
        .clk_i        (clk),
        .res_n_i      (resN),
        .sample_stb_i (stb2),
        .ch_data_i    (data2),
        .ch_vol_i     (vol2),
        .ch_route_i   (route2),
        .mute_i       (mute2),
        .dac_l_o      (dac2L),
        .dac_r_o      (dac2R),
        .busy_o       (busy2),
        .clip_o       (clip2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Offset-binary sample minus midscale, times gain, summed per side, floor-divided by 8.
    function automatic int mixModel(input logic [31:0] d, input logic [7:0] v,
                                    input logic [3:0] r, input int side);
        int sum = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (r[ch*2 + side]) begin
                sum += (int'(d[ch*IB +: IB]) - 32768) * int'(v[ch*4 +: 4]);
            end
        end
        return sum >>> 3;
    endfunction

    function automatic int satModel(input int m);
        if (m > 32767) return 32767;
        if (m < -32768) return -32768;
        return m;
    endfunction

    function automatic int withinOne(input int observed, input int expected);
        int diff = observed - expected;
        return (diff >= -1 && diff <= 1) ? expected : observed;
    endfunction

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] v, input logic [3:0] r);
        @(negedge clk);
        chData    = d;
        chVol     = v;
        chRoute   = r;
        sampleStb = 1'b1;
        @(negedge clk);
        sampleStb = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input logic [31:0] d,
                               input logic [7:0] v, input logic [3:0] r);
        int busyCycles = 0;
        int rawL = mixModel(d, v, r, 0);
        int rawR = mixModel(d, v, r, 1);
        int expClip = ((satModel(rawL) != rawL) || (satModel(rawR) != rawR)) ? 1 : 0;
        applyStimulus(d, v, r);
        for (int i = 0; i < 10 && busy; i++) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_busyCycles"}, busyCycles, NCH + 1);
        checkOutput({tag, "_mixL"}, int'($signed(dut.r_mixL)), satModel(rawL));
        checkOutput({tag, "_mixR"}, int'($signed(dut.r_mixR)), satModel(rawR));
        checkOutput({tag, "_clip"}, int'(clip), expClip);
        @(negedge clk);
        checkOutput({tag, "_clipEnd"}, int'(clip), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int onesL;
        int onesR;
        int zeros;
        logic [31:0] d;
        logic [7:0]  v;
        logic [3:0]  r;

        resN = 1'b0; sampleStb = 1'b0; chData = '0; chVol = '0; chRoute = '0; mute = 1'b0;
        stb2 = 1'b0; data2 = '0; vol2 = '0; route2 = '0; mute2 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_clip", int'(clip), 0);
        checkOutput("rst_dacL", int'(dacL), 0);
        checkOutput("rst_dacR", int'(dacR), 0);
        checkOutput("rst_mixL", int'($signed(dut.r_mixL)), 0);
        resN = 1'b1;
        @(negedge clk);

        runAndCheck("unity", {16'h8000, 16'hFFFF}, {4'd8, 4'd8}, {2'b11, 2'b01});
        onesL = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            onesL += int'(dacL);
        end
        checkOutput("unity_dutyL", withinOne(onesL, (4096 * 65535 + 32768) / 65536),
                    (4096 * 65535 + 32768) / 65536);

        runAndCheck("volZero", {16'hFFFF, 16'hFFFF}, {4'd0, 4'd8}, 4'b1111);
        runAndCheck("routeOff", {16'h0000, 16'hFFFF}, {4'd15, 4'd8}, {2'b00, 2'b11});

        for (int t = 0; t < 24; t++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                case ($urandom_range(0, 3))
                    0:       d[ch*IB +: IB] = 16'hFFFF;
                    1:       d[ch*IB +: IB] = 16'h0000;
                    default: d[ch*IB +: IB] = 16'($urandom());
                endcase
                v[ch*4 +: 4] = 4'($urandom_range(0, 15));
                r[ch*2 +: 2] = 2'($urandom_range(0, 3));
            end
            runAndCheck($sformatf("rand%0d", t), d, v, r);
        end

        @(negedge clk);
        chData = {16'h1111, 16'h2222}; chVol = {4'd8, 4'd8}; chRoute = 4'b0101; sampleStb = 1'b1;
        @(negedge clk);
        chData = {16'h0000, 16'h0000}; chVol = {4'd15, 4'd15}; chRoute = 4'b1111;
        @(negedge clk);
        chData = {16'hC000, 16'h4000}; chVol = {4'd8, 4'd4}; chRoute = 4'b1001;
        @(negedge clk);
        sampleStb = 1'b0;
        @(negedge clk);
        checkOutput("pend_firstMixL", int'($signed(dut.r_mixL)), satModel(mixModel({16'h1111, 16'h2222}, {4'd8, 4'd8}, 4'b0101, 0)));
        checkOutput("pend_noIdle", int'(busy), 1);
        repeat (3) @(negedge clk);
        checkOutput("pend_secondMixL", int'($signed(dut.r_mixL)), satModel(mixModel({16'hC000, 16'h4000}, {4'd8, 4'd4}, 4'b1001, 0)));
        checkOutput("pend_secondMixR", int'($signed(dut.r_mixR)), satModel(mixModel({16'hC000, 16'h4000}, {4'd8, 4'd4}, 4'b1001, 1)));
        checkOutput("pend_done", int'(busy), 0);

        runAndCheck("fullClip", 32'hFFFF_FFFF, 8'hFF, 4'b1111);
        mute = 1'b1;
        @(negedge clk);
        onesL = 0;
        onesR = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            onesL += int'(dacL);
            onesR += int'(dacR);
        end
        checkOutput("mute_dutyL", withinOne(onesL, 512), 512);
        checkOutput("mute_dutyR", withinOne(onesR, 512), 512);
        mute = 1'b0;

        applyStimulus(32'hFFFF_FFFF, 8'hFF, 4'b1111);
        @(posedge clk);
        #1 resN = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_clip", int'(clip), 0);
        checkOutput("abort_dacL", int'(dacL), 0);
        checkOutput("abort_dacR", int'(dacR), 0);
        checkOutput("abort_mixL", int'($signed(dut.r_mixL)), 0);
        repeat (4) @(negedge clk);
        checkOutput("abort_clipHeld", int'(clip), 0);
        resN = 1'b1;
        @(negedge clk);
        runAndCheck("afterAbort", {16'h9000, 16'h7000}, {4'd8, 4'd12}, {2'b10, 2'b11});

        repeat (8) @(negedge clk);
        onesL = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            onesL += int'(dac2L);
        end
        checkOutput("o2_midDuty", withinOne(onesL, 512), 512);

        @(negedge clk);
        data2 = {16'h8000, 16'h0000}; vol2 = {4'd8, 4'd8}; route2 = {2'b00, 2'b01}; stb2 = 1'b1;
        @(negedge clk);
        stb2 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("o2_mixL", int'($signed(dut2.r_mixL)), -32768);
        zeros = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            zeros += (dac2L == 1'b0) ? 1 : 0;
        end
        checkOutput("o2_zeroDuty", (zeros >= 19980) ? 19980 : zeros, 19980);
        checkOutput("o2_int2Sat", int'($signed(dut2.u_modL.g_order2.r_int2)), -524288);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
